// File: rtl/reg_share_arbiter_pkg.sv
// reg_share_arbiter_pkg
//   Shared types, default sizes and small helpers for the register-sharing
//   round-robin arbiter.
//   Contents:
//     arb_state_t          IDLE / GRANT controller state
//     DEF_N/DEF_W/DEF_MAX_HOLD   default requester count, data width, hold limit
//     idx_w(n)             width of an index into n requesters (min 1)
//     wrap_add(a, b, n)    (a + b) mod n for a, b already in [0, n)
package reg_share_arbiter_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int DEF_N        = 4;
  localparam int DEF_W        = 8;
  localparam int DEF_MAX_HOLD = 4;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/reg_share_arbiter_if.sv
// reg_share_arbiter_if
//   Bundle between the requesting blocks and the shared register arbiter.
//   Signals:
//     req   [N]      per-requester request level
//     data  [N*W]    requester i data word at [i*W +: W]
//     grant [N]      registered one-hot grant, zero when idle
//     owner [IDX_W]  index of current grantee (meaningful when grant != 0)
//     q     [W]      shared register contents
//     valid          high for the cycle after each edge that loaded q
//   Modports:
//     master  requester side (drives req/data)
//     slave   arbiter side (drives grant/owner/q/valid)
interface reg_share_arbiter_if
  import reg_share_arbiter_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) ();

  localparam int IDX_W = idx_w(N);

  logic [N-1:0]     req;
  logic [N*W-1:0]   data;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] owner;
  logic [W-1:0]     q;
  logic             valid;

  modport master (
    output req, data,
    input  grant, owner, q, valid
  );

  modport slave (
    input  req, data,
    output grant, owner, q, valid
  );

endinterface

// File: rtl/reg_share_arbiter_rr_pick.sv
// reg_share_arbiter_rr_pick
//   Combinational circular priority picker: finds the first asserted request
//   at or after i_ptr, wrapping from N-1 back to 0.
//   Ports:
//     i_req   [N]      request vector
//     i_ptr   [IDX_W]  highest-priority index
//     o_found          at least one request asserted
//     o_idx   [IDX_W]  winning index (0 when nothing found)
module reg_share_arbiter_rr_pick
  import reg_share_arbiter_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int IDX_W = idx_w(DEF_N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  // Walk offsets from farthest to nearest so the nearest hit is written last
  // and wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[IDX_W'(wrap_add(int'(i_ptr), k, N))]) begin
        o_found = 1'b1;
        o_idx   = IDX_W'(wrap_add(int'(i_ptr), k, N));
      end
    end
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter
//   Round-robin arbiter sharing one W-bit storage register among N requesters.
//   A requester raises req, gets a registered one-hot grant, then streams its
//   data word into q once per clock until it drops req. On release the pointer
//   moves past the old owner and arbitration reruns on the same edge, so a
//   waiting requester is granted with no idle cycle.
//   Optional feature macro: REG_ARB_TIMEOUT_EN -- when defined, an owner is
//   forced to release after MAX_HOLD captures in one grant and drops to lowest
//   priority; when undefined an owner keeps the grant until it drops req.
//   Ports:
//     i_clk     clock, all state updates on the rising edge
//     i_nreset  synchronous active-low reset
//     bus       reg_share_arbiter_if.slave (req/data in, grant/owner/q/valid out)
module reg_share_arbiter
  import reg_share_arbiter_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int W        = DEF_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic               i_clk,
  input  logic               i_nreset,
  reg_share_arbiter_if.slave bus
);

  localparam int IDX_W = idx_w(N);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_owner;
  logic [N-1:0]     r_grant;
  logic [W-1:0]     r_q;
  logic             r_valid;

  logic [W-1:0]     w_words [N];
  logic [IDX_W-1:0] w_next_ptr;
  logic [IDX_W-1:0] w_pick_ptr;
  logic             w_found;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_timeout;
  logic             w_capture;

  for (genvar gi = 0; gi < N; gi++) begin : g_words
    assign w_words[gi] = bus.data[gi*W +: W];
  end

  // Pointer just past the current owner; used both as the new ptr on release
  // and as the search start for the same-edge re-arbitration.
  assign w_next_ptr = (r_owner == IDX_W'(N - 1)) ? '0 : r_owner + 1'b1;
  assign w_pick_ptr = (r_state == GRANT) ? w_next_ptr : r_ptr;
  assign w_capture  = (r_state == GRANT) && bus.req[r_owner] && !w_timeout;

  reg_share_arbiter_rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req   (bus.req),
    .i_ptr   (w_pick_ptr),
    .o_found (w_found),
    .o_idx   (w_pick_idx)
  );

`ifdef REG_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] r_hold;

  assign w_timeout = (r_hold == HOLD_W'(MAX_HOLD));

  // Counts captures in the current grant; any non-capture edge in GRANT is a
  // release, which clears it.
  always_ff @(posedge i_clk) begin
    if (!i_nreset) begin
      r_hold <= '0;
    end else if (r_state == GRANT) begin
      if (w_capture) r_hold <= r_hold + 1'b1;
      else           r_hold <= '0;
    end
  end
`else
  logic w_unused_max_hold;

  assign w_timeout         = 1'b0;
  assign w_unused_max_hold = (MAX_HOLD > 0);
`endif

  always_ff @(posedge i_clk) begin
    if (!i_nreset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_grant <= '0;
      r_q     <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_valid <= 1'b0;
          if (w_found) begin
            r_grant <= N'(1) << w_pick_idx;
            r_owner <= w_pick_idx;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (w_capture) begin
            r_q     <= w_words[r_owner];
            r_valid <= 1'b1;
          end else begin
            r_valid <= 1'b0;
            r_ptr   <= w_next_ptr;
            if (w_found) begin
              r_grant <= N'(1) << w_pick_idx;
              r_owner <= w_pick_idx;
            end else begin
              r_grant <= '0;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.grant = r_grant;
  assign bus.owner = r_owner;
  assign bus.q     = r_q;
  assign bus.valid = r_valid;

endmodule
